// File: rtl/sma_sum_inverse.sv
// sma_sum_inverse
//   Inverse of the simple-moving-average filter. It takes a stream of
//   N-sample running sums s[n] = x[n] + ... + x[n-N+1] and rebuilds the
//   original samples with x[n] = s[n] - s[n-1] + x[n-N]. The history starts
//   at zero, which matches the filter's zero-initialised window, so the very
//   first sum reconstructs exactly.
//
// Ports
//   clk        in   clock
//   rstn       in   asynchronous active-low reset
//   clr        in   synchronous clear of all state; wins over in_valid
//   in_sum     in   moving sum s[n], unsigned, SUM_WIDTH bits
//   in_valid   in   qualifies in_sum, one sum per asserted cycle
//   out_data   out  reconstructed sample x[n], DATA_WIDTH bits
//   out_valid  out  one-cycle pulse qualifying out_data (latency 1)
//   out_primed out  high once NUM_SAMPLES samples were rebuilt since reset/clr
//   range_err  out  sticky flag: a reconstruction did not fit in DATA_WIDTH
//
// NUM_SAMPLES must be a power of two and at least 2, so the write pointer
// wraps naturally and SUM_WIDTH is strictly wider than DATA_WIDTH.
module sma_sum_inverse #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_SAMPLES = 4,
  localparam int SUM_WIDTH  = DATA_WIDTH + $clog2(NUM_SAMPLES)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic [SUM_WIDTH-1:0]  in_sum,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_primed,
  output logic                  range_err
);

  localparam int PTR_W = $clog2(NUM_SAMPLES);
  localparam int CNT_W = PTR_W + 1;
  localparam int EXT_W = SUM_WIDTH - DATA_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_SAMPLES);

  logic [SUM_WIDTH-1:0]  prev_sum_reg;
  logic [DATA_WIDTH-1:0] history_reg [NUM_SAMPLES];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [CNT_W-1:0]      cnt_reg;

  logic                  accept;
  logic [DATA_WIDTH-1:0] old_sample;
  logic [SUM_WIDTH-1:0]  recon;

  assign accept = in_valid && !clr;

  // The slot about to be overwritten holds x[n-N]; it is read before the
  // write of this cycle lands, so the history is a plain register array.
  assign old_sample = history_reg[wr_ptr_reg];

  // Modulo arithmetic in SUM_WIDTH: in_sum < prev_sum is legal after the
  // sum wraps, and the result is still correct modulo 2^SUM_WIDTH.
  assign recon = in_sum - prev_sum_reg + {{EXT_W{1'b0}}, old_sample};

  // History slots: each one is written only when the pointer selects it.
  generate
    for (genvar gi = 0; gi < NUM_SAMPLES; gi++) begin : g_hist
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          history_reg[gi] <= '0;
        end else if (clr) begin
          history_reg[gi] <= '0;
        end else if (accept && (wr_ptr_reg == PTR_W'(gi))) begin
          // Truncated value is stored on purpose: after a range error the
          // stream continues from what was actually emitted.
          history_reg[gi] <= recon[DATA_WIDTH-1:0];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_sum_reg <= '0;
      wr_ptr_reg   <= '0;
      cnt_reg      <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_primed   <= 1'b0;
      range_err    <= 1'b0;
    end else if (clr) begin
      prev_sum_reg <= '0;
      wr_ptr_reg   <= '0;
      cnt_reg      <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_primed   <= 1'b0;
      range_err    <= 1'b0;
    end else if (accept) begin
      prev_sum_reg <= in_sum;
      wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
      out_data     <= recon[DATA_WIDTH-1:0];
      out_valid    <= 1'b1;
      if (recon[SUM_WIDTH-1:DATA_WIDTH] != '0) begin
        range_err <= 1'b1;
      end
      if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      // Primed goes high together with the N-th output and stays there.
      if (cnt_reg >= CNT_MAX - CNT_W'(1)) begin
        out_primed <= 1'b1;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sma_sum_inverse.sv
// tb_sma_sum_inverse
//   Directed test-plan scenarios followed by randomized streams. The
//   reference model keeps the last N emitted samples in a queue and applies
//   x[n] = s[n] - s[n-1] + x[n-N] with plain arithmetic; a second random
//   phase builds sums from known samples and expects those samples back.
module tb_sma_sum_inverse;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int SW = DW + $clog2(N);

  logic          clk;
  logic          rstn;
  logic          clr;
  logic [SW-1:0] in_sum;
  logic          in_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_primed;
  logic          range_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [SW-1:0] m_prev;
  logic [DW-1:0] m_hist[$];
  int            m_cnt;
  bit            m_err;
  bit            m_valid;
  logic [DW-1:0] m_data;

  sma_sum_inverse #(.DATA_WIDTH(DW), .NUM_SAMPLES(N)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (clr),
    .in_sum     (in_sum),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_primed (out_primed),
    .range_err  (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_prev = '0;
    m_hist.delete();
    for (int i = 0; i < N; i++) m_hist.push_back('0);
    m_cnt   = 0;
    m_err   = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  task automatic model_accept(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s - m_prev + SW'(m_hist[0]);
    void'(m_hist.pop_front());
    m_hist.push_back(r[DW-1:0]);
    m_prev = s;
    if (r >= SW'(1 << DW)) m_err = 1'b1;
    if (m_cnt < N) m_cnt++;
    m_valid = 1'b1;
    m_data  = r[DW-1:0];
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".out_valid"},  32'(out_valid),  32'(m_valid));
    chk({ctx, ".out_data"},   32'(out_data),   32'(m_data));
    chk({ctx, ".out_primed"}, 32'(out_primed), 32'(m_cnt == N));
    chk({ctx, ".range_err"},  32'(range_err),  32'(m_err));
  endtask

  // One clock of stimulus; outputs are sampled 1 ns after the edge.
  task automatic step(input bit v, input logic [SW-1:0] s, input bit c);
    if (c) model_clear();
    else if (v) model_accept(s);
    else m_valid = 1'b0;
    in_valid = v;
    in_sum   = s;
    clr      = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
    $display("txn t=%0t valid=%0d clr=%0d sum=0x%0h -> out_valid=%0d out_data=0x%0h primed=%0d err=%0d",
             $time, v, c, s, out_valid, out_data, out_primed, range_err);
    check_outputs("step");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    model_clear();
    #1;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int s1_sum[5];
    int s1_exp[5];
    int fs_sum[5];
    logic [DW-1:0] xwin[$];
    logic [DW-1:0] x;
    logic [SW-1:0] acc;

    s1_sum = '{10, 30, 60, 100, 140};
    s1_exp = '{10, 20, 30, 40, 50};
    fs_sum = '{32'hFFFF, 32'h1FFFE, 32'h2FFFD, 32'h3FFFC, 32'h3FFFC};

    rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; in_sum = '0;
    model_clear();

    // Scenario 1: basic reconstruction, primed on the 4th output
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, SW'(s1_sum[i]), 1'b0);
      chk("s1_data", 32'(out_data), 32'(s1_exp[i]));
      chk("s1_primed", 32'(out_primed), (i >= 3) ? 32'd1 : 32'd0);
    end
    step(1'b0, '0, 1'b0);
    chk("s1_hold", 32'(out_data), 32'd50);

    // Scenario 2: full-scale samples, pointer wrap
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, SW'(fs_sum[i]), 1'b0);
      chk("fs_data", 32'(out_data), 32'hFFFF);
      chk("fs_err", 32'(range_err), 32'd0);
    end

    // Scenario 3: range error, clear, recovery
    do_reset();
    step(1'b1, SW'(32'h10000), 1'b0);
    chk("err_data", 32'(out_data), 32'h0);
    chk("err_flag", 32'(range_err), 32'd1);
    step(1'b0, '0, 1'b0);
    chk("err_sticky", 32'(range_err), 32'd1);
    step(1'b0, '0, 1'b1);
    chk("err_clr", 32'(range_err), 32'd0);
    step(1'b1, SW'(5), 1'b0);
    chk("err_recover", 32'(out_data), 32'd5);

    // Scenario 4: three idle cycles between sums
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, SW'(s1_sum[i]), 1'b0);
      chk("gap_data", 32'(out_data), 32'(s1_exp[i]));
      for (int k = 0; k < 3; k++) begin
        step(1'b0, SW'($urandom), 1'b0);
        chk("gap_novalid", 32'(out_valid), 32'd0);
      end
    end

    // Scenario 5: clr together with in_valid discards the sample
    do_reset();
    step(1'b1, SW'(10), 1'b0);
    step(1'b1, SW'(30), 1'b1);
    chk("clrv_novalid", 32'(out_valid), 32'd0);
    step(1'b1, SW'(7), 1'b0);
    chk("clrv_data", 32'(out_data), 32'd7);

    // Scenario 6: asynchronous reset mid-stream
    do_reset();
    step(1'b1, SW'(10), 1'b0);
    step(1'b1, SW'(30), 1'b0);
    #2;
    rstn = 1'b0;
    model_clear();
    #1;
    check_outputs("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    step(1'b1, SW'(60), 1'b0);
    chk("async_data", 32'(out_data), 32'd60);

    // Random phase A: sums built from known samples must give them back
    do_reset();
    xwin.delete();
    for (int i = 0; i < N; i++) xwin.push_back('0);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step(1'b0, SW'($urandom), 1'b0);
      end else begin
        x = DW'($urandom);
        void'(xwin.pop_front());
        xwin.push_back(x);
        acc = '0;
        foreach (xwin[j]) acc = acc + SW'(xwin[j]);
        step(1'b1, acc, 1'b0);
        chk("rand_x", 32'(out_data), 32'(x));
        chk("rand_noerr", 32'(range_err), 32'd0);
      end
    end

    // Random phase B: arbitrary sums with occasional clears
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 4) != 0), SW'($urandom), ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
